// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared types and constants for the serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int SLICE_W = 4;

endpackage

`default_nettype wire

// File: rtl/fulladder4.sv
// ============================================================================
// fulladder4 : 4-bit ripple adder slice with carry in/out
// Rev 1.0
// ============================================================================
`default_nettype none

module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : WIDTH-bit adder built by reusing one 4-bit slice,
// LSB nibble first, with valid/ready handshakes on both sides.  Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int STEP_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSLICE - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  sadd_state_t        r_state;
  logic [STEP_W-1:0]  r_step;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_valid;

  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_sum_slice;
  logic               w_slice_carry;

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_step == STEP_W'(k)) begin
        w_a_slice = r_a[k*SLICE_W +: SLICE_W];
        w_b_slice = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  fulladder4 u_slice (
    .a_i     (w_a_slice),
    .b_i     (w_b_slice),
    .carry_i (r_carry),
    .sum_o   (w_sum_slice),
    .carry_o (w_slice_carry)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_carry <= carry_i;
            r_sum   <= '0;
            r_step  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_step == STEP_W'(k)) begin
              r_sum[k*SLICE_W +: SLICE_W] <= w_sum_slice;
            end
          end
          r_carry <= w_slice_carry;
          r_step  <= r_step + STEP_W'(1);
          if (r_step == LAST_STEP) begin
            r_carry_out <= w_slice_carry;
            r_valid     <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result stays on sum_o/carry_o after the handshake until the next accept.
          if (ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = (r_state == IDLE);
  assign busy_o  = (r_state == RUN);
  assign sum_o   = r_sum;
  assign carry_o = r_carry_out;
  assign valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// tb_serial_adder_ctrl : table vectors, directed handshake/reset sequences and
// random traffic against a scoreboard for serial_adder_ctrl.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int NSL   = WIDTH / 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             carry_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic             busy_o;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] sum;
    logic             co;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_hs = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   rnd_ready = 1'b0;
  bit   ready_fix = 1'b1;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Sole driver of ready_i; lands after the main thread's +1 updates.
  always @(posedge clk_i) begin
    #2;
    ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A result is taken when valid_o && ready_i hold over the next rising edge.
  always @(negedge clk_i) begin
    if (rst_i && valid_o && ready_i) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got sum %h carry %b with nothing outstanding", sum_o, carry_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_sum", 64'(sum_o), 64'(e.sum));
        chk("result_carry", 64'(carry_o), 64'(e.co));
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic [WIDTH-1:0] es, input logic eco,
                      input bit scramble);
    int   t;
    exp_t e;
    t = 0;
    a_i = a; b_i = b; carry_i = ci; valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: ready_o stuck at 0 expected 1");
      valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    acc_cyc = cyc;
    n_acc++;
    e.sum = es; e.co = eco;
    sb.push_back(e);
    if (scramble) begin
      for (int k = 0; k < NSL; k++) begin
        a_i = $urandom; b_i = $urandom; carry_i = 1'($urandom);
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(sb.size() == 0 && ready_o) && t < 500) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    if (!(sb.size() == 0 && ready_o)) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, ready_o %b expected 0 outstanding", sb.size(), ready_o);
      sb.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   last;
    logic [WIDTH:0] ref_val;
    logic [WIDTH-1:0] ra, rb;
    logic rci;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[6] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0};
    vecs[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_sum", 64'(sum_o), 64'd0);
    chk("rst_carry", 64'(carry_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Latency / busy window on the wrap-around case
    ready_fix = 1'b1;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    for (int k = 0; k < NSL; k++) begin
      chk("run_busy", 64'(busy_o), 64'd1);
      chk("run_valid", 64'(valid_o), 64'd0);
      chk("run_ready", 64'(ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    chk("done_valid", 64'(valid_o), 64'd1);
    chk("done_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("after_hs_valid", 64'(valid_o), 64'd0);
    chk("after_hs_ready", 64'(ready_o), 64'd1);
    chk("after_hs_sum_held", 64'(sum_o), 64'd0);
    chk("after_hs_carry_held", 64'(carry_o), 64'd1);

    // Table vectors
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co, 1'b0);
      wait_idle();
    end

    // Back-to-back period with ready_i high
    last = -1;
    for (int i = 0; i < 4; i++) begin
      send(32'h00001111 * (i + 1), 32'h00000101, 1'b0, 32'h00001111 * (i + 1) + 32'h00000101, 1'b0, 1'b0);
      if (last >= 0) chk("b2b_period", 64'(acc_cyc - last), 64'(NSL + 2));
      last = acc_cyc;
    end
    wait_idle();

    // Backpressure: result held, no accept while ready_i low
    ready_fix = 1'b0;
    send(32'h00000100, 32'h00000200, 1'b1, 32'h00000301, 1'b0, 1'b0);
    repeat (NSL) @(posedge clk_i);
    #1;
    a_i = 32'h11111111; b_i = 32'h22222222; carry_i = 1'b0; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_ready", 64'(ready_o), 64'd0);
      chk("bp_sum", 64'(sum_o), 64'h301);
      chk("bp_carry", 64'(carry_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    ready_fix = 1'b1;
    @(posedge clk_i);
    #1;
    chk("bp_release_ready", 64'(ready_o), 64'd1);
    chk("bp_release_valid", 64'(valid_o), 64'd0);
    begin
      exp_t e;
      e.sum = 32'h33333333; e.co = 1'b0;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("bp_accept_busy", 64'(busy_o), 64'd1);
    wait_idle();

    // Reset during RUN discards the in-flight add
    send(32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0001FFFE, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb.delete();
    n_acc = n_hs;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_sum", 64'(sum_o), 64'd0);
    chk("midrst_carry", 64'(carry_o), 64'd0);
    send(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);
    wait_idle();

    // Operands changing during RUN must not matter
    send(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b1);
    wait_idle();

    // Random traffic against a+b+ci reference
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
      ra = $urandom; rb = $urandom; rci = 1'($urandom);
      ref_val = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci};
      send(ra, rb, rci, ref_val[WIDTH-1:0], ref_val[WIDTH], 1'b0);
    end
    wait_idle();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("handshake_count", 64'(n_hs), 64'(n_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Multi-cycle controller that performs a WIDTH-bit addition by time-multiplexing one fulladder4 slice over WIDTH/4 clock cycles, least-significant nibble first, with the carry registered between slices. Operands come in on a valid/ready handshake and the result goes out on a second valid/ready handshake. This lets a wide adder be built from the existing 4-bit adder at the cost of latency, and gives the adder lab a sequential follow-on block.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of 4 and at least 4 (elaboration $error otherwise).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; synchronous, active-low
a_i  input  WIDTH  operand A, sampled on input handshake
b_i  input  WIDTH  operand B, sampled on input handshake
carry_i  input  1  carry-in, sampled on input handshake
valid_i  input  1  operands valid
ready_o  output  1  controller can accept operands
sum_o  output  WIDTH  result sum
carry_o  output  1  result carry-out
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
busy_o  output  1  high while in RUN

Behaviour:
- Reset: when rst_i==0 at a rising edge, the next state is IDLE.
  - sum_o=0, carry_o=0, valid_o=0, busy_o=0, ready_o=1, step counter=0.
  - Reset wins over every other event, including reset in the middle of RUN or in DONE; any in-flight result is discarded.
- States (enum in package): IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: latch a_i, b_i and carry_i into internal registers, clear sum_o, set step=0, go to RUN.
- RUN:
  - ready_o=0, busy_o=1.
  - Each cycle the fulladder4 instance adds a_reg[4*step+:4], b_reg[4*step+:4] and carry_reg.
  - At the edge, write the 4-bit sum into sum_o[4*step+:4] and the slice carry into carry_reg, then step++.
  - When step==WIDTH/4-1 at the edge: carry_o takes the final slice carry, valid_o goes to 1, go to DONE.
  - Operand inputs and valid_i are ignored during RUN; changes to a_i/b_i do not affect the result.
- Latency: valid_o rises exactly WIDTH/4 rising edges after the accepting edge (8 for WIDTH=32; 1 for WIDTH=4, where RUN lasts a single cycle).
- DONE:
  - valid_o=1, ready_o=0, busy_o=0.
  - sum_o and carry_o are held stable until the output handshake.
  - On valid_o&&ready_i: valid_o goes to 0 and the state goes to IDLE. sum_o and carry_o keep their values until the next accept.
- No overlap: a new operand is never accepted in the same cycle as a result handshake.
  - Minimum period with ready_i held at 1 is WIDTH/4+2 cycles (10 for WIDTH=32).
- Arithmetic: {carry_o,sum_o} = a + b + carry_i, taken modulo 2^(WIDTH+1). Wrap-around appears only as carry_o.
- step counter width: $clog2(WIDTH/4), with a minimum of 1 bit.
- ready_o and busy_o are decoded combinationally from the state. sum_o, carry_o and valid_o are registers.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t
  - localparam SLICE_W = 4
- Sub-module: a single instance of the existing fulladder4 (a_i, b_i, carry_i, sum_o, carry_o) as the slice datapath. No other sub-modules.

Test Plan:
1. WIDTH=32; a=0xFFFFFFFF, b=0x00000001, ci=0; ready_i=1 -> sum_o=0x00000000, carry_o=1, valid_o rises 8 edges after the accept and is high for 1 cycle, busy_o high for 8 cycles.
2. a=0x12345678, b=0x87654321, ci=1 -> sum_o=0x9999999A, carry_o=0. Then a=0x80000000, b=0x80000000, ci=0 -> sum_o=0, carry_o=1.
3. Backpressure: after a result, hold ready_i=0 for 5 cycles while valid_i=1 with new operands -> sum_o/carry_o/valid_o stable, ready_o=0, no new accept. ready_i=1 -> next cycle IDLE, the following edge accepts.
4. Reset mid-op: rst_i=0 for one edge at step 3 of RUN -> next cycle valid_o=0, busy_o=0, ready_o=1, sum_o=0, carry_o=0. A new add of 0x00000005+0x00000003 then yields 0x00000008.
5. Operand hold-off: change a_i/b_i every cycle during RUN after accepting 0x0F0F0F0F+0x01010101 -> result 0x10101010, carry_o=0.
6. Random: 1000 transactions with a random ready_i/valid_i pattern against a reference model computing a+b+ci -> every result matches, each accept yields exactly one valid_o handshake, and the 10-cycle back-to-back period holds with ready_i=1.
